// File: rtl/btn_debounce_pkg.sv
// Shared types and default parameters for the multi-channel button debouncer.
// Optional long-press detection is enabled by defining LONG_PRESS_EN.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    PEND_HI = 2'd1,
    IDLE_HI = 2'd2,
    PEND_LO = 2'd3
  } btn_state_e;

  localparam int DEF_CH         = 4;
  localparam int DEF_TICK_DIV   = 65536;
  localparam int DEF_STABLE_CNT = 3;
  localparam int DEF_ACTIVE_LOW = 0;
  localparam int DEF_LONG_TICKS = 500;

  // The accepted level stays high while a release is still being qualified.
  function automatic logic state_is_high(input btn_state_e st);
    return (st == IDLE_HI) || (st == PEND_LO);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, tick-driven qualify FSM, strobes.
// Long-press counter is present only when LONG_PRESS_EN is defined.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_raw,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output btn_state_e state_o
);

  localparam int              SW       = $clog2(STABLE_CNT + 1);
  localparam logic            IDLE_RAW = (ACTIVE_LOW != 0);
  localparam logic [SW-1:0]   CNT_LAST = SW'(STABLE_CNT - 1);

  if (STABLE_CNT < 1) begin : g_bad_stable
    $error("STABLE_CNT must be at least 1");
  end
  if (LONG_TICKS < 1) begin : g_bad_long
    $error("LONG_TICKS must be at least 1");
  end

  logic [1:0]    sync_q, sync_d;
  btn_state_e    state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          s;

  assign sync_d = {sync_q[0], btn_raw};
  assign s      = sync_q[1] ^ IDLE_RAW;

  // cnt holds the number of matching samples already seen in a PEND state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            if (CNT_LAST == '0) begin
              state_d = IDLE_HI;
              press_d = 1'b1;
            end else begin
              state_d = PEND_HI;
              cnt_d   = SW'(1);
            end
          end
        end
        PEND_HI: begin
          if (!s) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
        IDLE_HI: begin
          if (!s) begin
            if (CNT_LAST == '0) begin
              state_d   = IDLE_LO;
              release_d = 1'b1;
            end else begin
              state_d = PEND_LO;
              cnt_d   = SW'(1);
            end
          end
        end
        PEND_LO: begin
          if (s) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE_LO;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
        default: begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {2{IDLE_RAW}};
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef LONG_PRESS_EN
  localparam int            LW       = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);

  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_q, long_d;
  logic          btn_level;

  assign btn_level = state_is_high(state_q);

  // Saturating at LONG_MAX keeps the strobe to one per press.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (!btn_level) begin
      long_cnt_d = '0;
    end else if (tick && (long_cnt_q != LONG_MAX)) begin
      long_cnt_d = long_cnt_q + LW'(1);
      long_d     = (long_cnt_q == (LONG_MAX - LW'(1)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer: one shared sample prescaler feeding CH
// independent channels. Define LONG_PRESS_EN to enable the LONG strobes.
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int CH         = DEF_CH,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CH-1:0] IN_BTN,
  output logic [CH-1:0] OUT_BTN,
  output logic [CH-1:0] PRESS,
  output logic [CH-1:0] RELEASE,
  output logic [CH-1:0] LONG,
  output logic          TICK
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (CH < 1) begin : g_bad_ch
    $error("CH must be at least 1");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end

  logic [PW-1:0] pre_q, pre_d;

  assign pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign TICK = (pre_q == PRE_LAST);

  btn_state_e ch_state [CH];

  for (genvar i = 0; i < CH; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .ACTIVE_LOW (ACTIVE_LOW),
      .LONG_TICKS (LONG_TICKS)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (RST),
      .tick      (TICK),
      .btn_raw   (IN_BTN[i]),
      .press_o   (PRESS[i]),
      .release_o (RELEASE[i]),
      .long_o    (LONG[i]),
      .state_o   (ch_state[i])
    );

    assign OUT_BTN[i] = state_is_high(ch_state[i]);
  end

endmodule
